sprite_motion_ctrl: RTL and testbench

Frame-paced movement controller for the player sprite. It turns raw keyboard scancodes into position steps: one step at the first frame after a press, a hold-off delay, then auto-repeat at a fixed frame rate. Each step is clamped to the visible playfield. It sits between the USB keyboard scancode register and the sprite renderer, and drives sprite_x/sprite_y once per video frame instead of once per clock.

---
 rtl/sprite_motion_ctrl.sv | 103 ++++++++++
 tb/tb_sprite_motion_ctrl.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/sprite_motion_ctrl.sv
// sprite_motion_ctrl: frame-paced sprite mover with press, hold-off and auto-repeat steps clamped to the playfield
module sprite_motion_ctrl #(
  parameter int X_INIT        = 320,
  parameter int Y_INIT        = 240,
  parameter int X_MIN         = 0,
  parameter int X_MAX         = 623,
  parameter int Y_MIN         = 0,
  parameter int Y_MAX         = 463,
  parameter int STEP          = 1,
  parameter int REPEAT_DELAY  = 8,
  parameter int REPEAT_PERIOD = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic [7:0] key_code,
  output logic [9:0] sprite_x,
  output logic [9:0] sprite_y,
  output logic       moving,
  output logic       edge_hit
);
  typedef enum logic [1:0] {IDLE, ARMED, HOLD, REPEAT} state_t;
  localparam logic [7:0] K_UP = 8'h75, K_DOWN = 8'h72, K_LEFT = 8'h6B, K_RIGHT = 8'h74;
  localparam logic signed [10:0] XLO = 11'(X_MIN), XHI = 11'(X_MAX);
  localparam logic signed [10:0] YLO = 11'(Y_MIN), YHI = 11'(Y_MAX);
  localparam logic signed [10:0] SSTEP = 11'(STEP);
  state_t state, state_n;
  logic [5:0] cnt, cnt_n, cnt_inc;
  logic [7:0] key_q;
  logic [1:0] dir_q, dir_n, key_dir;
  logic is_dir, new_press, step, sel_y, dec;
  logic signed [10:0] cur, lo, hi, raw, clamped;
  // dir encoding: bit1 clear selects y, bit0 clear means decrement
  assign key_dir = key_code == K_UP ? 2'd0 : key_code == K_DOWN ? 2'd1 : key_code == K_LEFT ? 2'd2 : 2'd3;
  assign is_dir = key_code == K_UP || key_code == K_DOWN || key_code == K_LEFT || key_code == K_RIGHT;
  assign new_press = is_dir && key_code != key_q;
  assign cnt_inc = cnt + 6'd1;
  assign moving = state != IDLE;
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    dir_n = dir_q;
    step = 1'b0;
    if (!is_dir) begin
      state_n = IDLE;
      cnt_n = '0;
    end else if (new_press) begin
      state_n = ARMED;
      cnt_n = '0;
      dir_n = key_dir;
    end else if (frame_tick) begin
      case (state)
        ARMED: begin
          step = 1'b1;
          state_n = HOLD;
          cnt_n = '0;
        end
        HOLD: begin
          cnt_n = cnt_inc;
          if (cnt_inc == 6'(REPEAT_DELAY)) begin
            step = 1'b1;
            state_n = REPEAT;
            cnt_n = '0;
          end
        end
        REPEAT: begin
          cnt_n = cnt_inc;
          if (cnt_inc == 6'(REPEAT_PERIOD)) begin
            step = 1'b1;
            cnt_n = '0;
          end
        end
        default: ;
      endcase
    end
  end
  assign sel_y = ~dir_q[1];
  assign dec = ~dir_q[0];
  assign cur = sel_y ? $signed({1'b0, sprite_y}) : $signed({1'b0, sprite_x});
  assign lo = sel_y ? YLO : XLO;
  assign hi = sel_y ? YHI : XHI;
  assign raw = dec ? cur - SSTEP : cur + SSTEP;
  assign clamped = raw < lo ? lo : raw > hi ? hi : raw;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt <= '0;
      key_q <= 8'h00;
      dir_q <= 2'd3;
      sprite_x <= 10'(X_INIT);
      sprite_y <= 10'(Y_INIT);
      edge_hit <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      key_q <= key_code;
      dir_q <= dir_n;
      edge_hit <= step && raw != clamped;
      if (step && sel_y) sprite_y <= clamped[9:0];
      if (step && !sel_y) sprite_x <= clamped[9:0];
    end
  end
endmodule

// File: tb/tb_sprite_motion_ctrl.sv
// tb_sprite_motion_ctrl: directed checks of press/hold/repeat timing, release, clamping and async reset
module tb_sprite_motion_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic frame_tick = 1'b0;
  logic [7:0] key_code = 8'h00;
  logic [9:0] x0, y0, x1, y1, x2, y2;
  logic mv0, eh0, mv1, eh1, mv2, eh2;
  int n_assert = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  sprite_motion_ctrl dut0 (.clk(clk), .reset(reset), .frame_tick(frame_tick), .key_code(key_code),
    .sprite_x(x0), .sprite_y(y0), .moving(mv0), .edge_hit(eh0));
  sprite_motion_ctrl #(.X_INIT(1), .STEP(2)) dut1 (.clk(clk), .reset(reset), .frame_tick(frame_tick),
    .key_code(key_code), .sprite_x(x1), .sprite_y(y1), .moving(mv1), .edge_hit(eh1));
  sprite_motion_ctrl #(.X_INIT(622), .STEP(2)) dut2 (.clk(clk), .reset(reset), .frame_tick(frame_tick),
    .key_code(key_code), .sprite_x(x2), .sprite_y(y2), .moving(mv2), .edge_hit(eh2));
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic tick();
    @(negedge clk);
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
  endtask
  task automatic pulse_reset();
    reset = 1'b0;
    cyc(1);
    reset = 1'b1;
  endtask
  initial begin
    cyc(3);
    chk("rst_x", x0, 320);
    chk("rst_y", y0, 240);
    chk("rst_moving", mv0, 0);
    chk("rst_edge", eh0, 0);
    chk("rst_x_dut1", x1, 1);
    chk("rst_x_dut2", x2, 622);
    reset = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("idle_edge", eh0, 0);
    end
    chk("idle_x", x0, 320);
    chk("idle_y", y0, 240);
    chk("idle_moving", mv0, 0);
    key_code = 8'h74;
    cyc(1);
    chk("press_moving", mv0, 1);
    chk("press_x", x0, 320);
    for (int k = 1; k <= 12; k++) begin
      tick();
      chk("repeat_x", x0, k >= 11 ? 323 : k >= 9 ? 322 : 321);
      chk("repeat_y", y0, 240);
      chk("repeat_moving", mv0, 1);
      chk("repeat_edge", eh0, 0);
    end
    key_code = 8'h00;
    cyc(1);
    chk("release_moving", mv0, 0);
    key_code = 8'h72;
    cyc(1);
    chk("down_moving", mv0, 1);
    key_code = 8'h00;
    cyc(1);
    chk("cancel_moving", mv0, 0);
    repeat (3) tick();
    chk("cancel_y", y0, 240);
    chk("cancel_x", x0, 323);
    pulse_reset();
    chk("reset2_x", x0, 320);
    key_code = 8'h74;
    tick();
    chk("switch_first_x", x0, 321);
    tick();
    tick();
    key_code = 8'h75;
    cyc(1);
    tick();
    chk("switch_y", y0, 239);
    chk("switch_x", x0, 321);
    for (int k = 0; k < 7; k++) begin
      tick();
      chk("switch_hold_y", y0, 239);
    end
    tick();
    chk("switch_repeat_y", y0, 238);
    chk("switch_repeat_x", x0, 321);
    key_code = 8'h00;
    pulse_reset();
    key_code = 8'h6B;
    tick();
    chk("clampl_x", x1, 0);
    chk("clampl_edge", eh1, 1);
    cyc(1);
    chk("clampl_edge_pulse", eh1, 0);
    for (int k = 2; k <= 8; k++) begin
      tick();
      chk("clampl_hold_edge", eh1, 0);
      chk("clampl_hold_x", x1, 0);
    end
    tick();
    chk("clampl_again_x", x1, 0);
    chk("clampl_again_edge", eh1, 1);
    key_code = 8'h00;
    pulse_reset();
    key_code = 8'h74;
    tick();
    chk("clampr_x", x2, 623);
    chk("clampr_edge", eh2, 1);
    cyc(1);
    chk("clampr_edge_pulse", eh2, 0);
    repeat (7) tick();
    chk("clampr_hold_edge", eh2, 0);
    tick();
    chk("clampr_again_x", x2, 623);
    chk("clampr_again_edge", eh2, 1);
    key_code = 8'h00;
    pulse_reset();
    key_code = 8'h74;
    frame_tick = 1'b1;
    cyc(1);
    frame_tick = 1'b0;
    chk("collide_x", x0, 320);
    chk("collide_moving", mv0, 1);
    tick();
    chk("collide_next_x", x0, 321);
    repeat (8) tick();
    chk("collide_second_x", x0, 322);
    tick();
    #2 reset = 1'b0;
    #1;
    chk("async_x", x0, 320);
    chk("async_y", y0, 240);
    chk("async_moving", mv0, 0);
    chk("async_edge", eh0, 0);
    @(negedge clk);
    reset = 1'b1;
    cyc(1);
    chk("held_after_reset_moving", mv0, 1);
    tick();
    chk("held_after_reset_x", x0, 321);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
